// File: rtl/penalty_round_ctl.sv
// penalty_round_ctl: sequences one penalty shootout (aim, shot, result, over),
// alternating shooter/keeper, timing each shot and tallying goals per side.
// Optional build macro SUDDEN_DEATH_EN: a tie after regulation continues with
// extra full rounds instead of ending as a draw.
module penalty_round_ctl #(
  parameter int unsigned ROUNDS       = 5,
  parameter int unsigned SHOT_TIMEOUT = 65_000_000,
  parameter int unsigned RESULT_HOLD  = 130_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left_clicked,
  input  logic       shot_done,
  input  logic       shot_goal,
  output logic [2:0] phase,
  output logic       player_shoots,
  output logic [3:0] round,
  output logic [3:0] score_player,
  output logic [3:0] score_opp,
  output logic       shot_fire,
  output logic       last_goal,
  output logic       timed_out,
  output logic [1:0] winner
);

  localparam int unsigned TMAX = (SHOT_TIMEOUT > RESULT_HOLD) ? SHOT_TIMEOUT : RESULT_HOLD;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] SHOT_LAST = TW'(SHOT_TIMEOUT - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(RESULT_HOLD - 1);
  localparam logic [5:0]    ROUNDS_W  = 6'(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_AIM    = 3'd1,
    S_SHOT   = 3'd2,
    S_RESULT = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t        state_q, state_n;
  logic [TW-1:0] timer_q, timer_n;
  logic          lc_q, click_q;
  logic [3:0]    round_q, round_n;
  logic [3:0]    sp_q, sp_n, so_q, so_n;
  logic          ps_q, ps_n;
  logic          fire_n;
  logic          lg_q, lg_n, to_q, to_n;
  logic [1:0]    win_q, win_n;

  // Decision helpers evaluated at the end of the result hold
  logic [5:0] rnd6, sp6, so6, rem_p, rem_o;
  logic       in_reg, early, reg_done, tied, go_over;
  logic [1:0] lead;

  // Regulation shots still owed per side, early decision and end-of-match test
  always_comb begin
    rnd6   = {2'b00, round_q};
    sp6    = {2'b00, sp_q};
    so6    = {2'b00, so_q};
    in_reg = (rnd6 <= ROUNDS_W);
    rem_p  = in_reg ? (ROUNDS_W - rnd6) : '0;
    // After the player's shot the opponent still owes this round's shot
    rem_o  = (in_reg && ps_q) ? (rem_p + 6'd1) : rem_p;
    early  = in_reg && ((sp6 > so6 + rem_o) || (so6 > sp6 + rem_p));
    reg_done = !ps_q && (rnd6 >= ROUNDS_W);
    tied   = (sp_q == so_q);
    if (sp_q > so_q)      lead = 2'b01;
    else if (so_q > sp_q) lead = 2'b10;
    else                  lead = 2'b11;
`ifdef SUDDEN_DEATH_EN
    go_over = early || (reg_done && (!tied || round_q == 4'hF));
`else
    go_over = early || reg_done;
`endif
  end

  // Next-state and next-output logic for the shootout sequencer
  always_comb begin
    state_n = state_q;
    timer_n = timer_q + TW'(1);
    round_n = round_q;
    sp_n    = sp_q;
    so_n    = so_q;
    ps_n    = ps_q;
    fire_n  = 1'b0;
    lg_n    = lg_q;
    to_n    = to_q;
    win_n   = win_q;
    unique case (state_q)
      S_IDLE: begin
        timer_n = '0;
        if (click_q) begin
          state_n = S_AIM;
          round_n = 4'd1;
          ps_n    = 1'b1;
          sp_n    = '0;
          so_n    = '0;
          win_n   = '0;
          lg_n    = 1'b0;
          to_n    = 1'b0;
        end
      end
      S_AIM: begin
        if (timer_q == SHOT_LAST) begin
          state_n = S_RESULT;
          lg_n    = 1'b0;
          to_n    = 1'b1;
        end else if (click_q) begin
          state_n = S_SHOT;
          fire_n  = 1'b1;
        end
      end
      S_SHOT: begin
        if (shot_done) begin
          state_n = S_RESULT;
          lg_n    = shot_goal;
          to_n    = 1'b0;
          if (shot_goal) begin
            if (ps_q) sp_n = (sp_q == 4'hF) ? sp_q : sp_q + 4'd1;
            else      so_n = (so_q == 4'hF) ? so_q : so_q + 4'd1;
          end
        end else if (timer_q == SHOT_LAST) begin
          state_n = S_RESULT;
          lg_n    = 1'b0;
          to_n    = 1'b1;
        end
      end
      S_RESULT: begin
        if (timer_q == HOLD_LAST) begin
          to_n = 1'b0;
          if (go_over) begin
            state_n = S_OVER;
            win_n   = lead;
          end else if (ps_q) begin
            state_n = S_AIM;
            ps_n    = 1'b0;
          end else begin
            state_n = S_AIM;
            ps_n    = 1'b1;
            round_n = (round_q == 4'hF) ? round_q : round_q + 4'd1;
          end
        end
      end
      S_OVER: begin
        timer_n = '0;
        if (click_q) begin
          state_n = S_IDLE;
          round_n = '0;
          sp_n    = '0;
          so_n    = '0;
          ps_n    = 1'b0;
          lg_n    = 1'b0;
          to_n    = 1'b0;
          win_n   = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
    endcase
    // One shared timer: the shot timeout spans aim and flight, so AIM->SHOT
    // keeps counting; every other phase change restarts it
    if (state_n != state_q && !(state_q == S_AIM && state_n == S_SHOT))
      timer_n = '0;
  end

  // State, timer, click edge detector and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      lc_q    <= 1'b0;
      click_q <= 1'b0;
      round_q <= '0;
      sp_q    <= '0;
      so_q    <= '0;
      ps_q    <= 1'b0;
      shot_fire <= 1'b0;
      lg_q    <= 1'b0;
      to_q    <= 1'b0;
      win_q   <= '0;
    end else begin
      state_q <= state_n;
      timer_q <= timer_n;
      lc_q    <= left_clicked;
      click_q <= left_clicked & ~lc_q;
      round_q <= round_n;
      sp_q    <= sp_n;
      so_q    <= so_n;
      ps_q    <= ps_n;
      shot_fire <= fire_n;
      lg_q    <= lg_n;
      to_q    <= to_n;
      win_q   <= win_n;
    end
  end

  assign phase         = state_q;
  assign player_shoots = ps_q;
  assign round         = round_q;
  assign score_player  = sp_q;
  assign score_opp     = so_q;
  assign last_goal     = lg_q;
  assign timed_out     = to_q;
  assign winner        = win_q;

endmodule

// File: tb/tb_penalty_round_ctl.sv
// Directed bench for penalty_round_ctl with ROUNDS=3, SHOT_TIMEOUT=20,
// RESULT_HOLD=4. Inputs are driven and outputs sampled on the falling edge.
module tb_penalty_round_ctl;

  logic       clk;
  logic       rst;
  logic       left_clicked;
  logic       shot_done;
  logic       shot_goal;
  logic [2:0] phase;
  logic       player_shoots;
  logic [3:0] round;
  logic [3:0] score_player;
  logic [3:0] score_opp;
  logic       shot_fire;
  logic       last_goal;
  logic       timed_out;
  logic [1:0] winner;

  int n_total = 0;
  int n_pass  = 0;

  penalty_round_ctl #(
    .ROUNDS       (3),
    .SHOT_TIMEOUT (20),
    .RESULT_HOLD  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .left_clicked  (left_clicked),
    .shot_done     (shot_done),
    .shot_goal     (shot_goal),
    .phase         (phase),
    .player_shoots (player_shoots),
    .round         (round),
    .score_player  (score_player),
    .score_opp     (score_opp),
    .shot_fire     (shot_fire),
    .last_goal     (last_goal),
    .timed_out     (timed_out),
    .winner        (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One-cycle press; the registered edge detect acts one edge later
  task automatic click();
    left_clicked = 1'b1;
    tick();
    left_clicked = 1'b0;
    tick();
  endtask

  task automatic take_shot(input logic goal);
    click();
    chk("shot_fire", 32'(shot_fire), 1);
    shot_done = 1'b1;
    shot_goal = goal;
    tick();
    shot_done = 1'b0;
    shot_goal = 1'b0;
    chk("result_phase", 32'(phase), 3);
    chk("last_goal", 32'(last_goal), int'(goal));
    chk("not_timed_out", 32'(timed_out), 0);
  endtask

  task automatic hold_result();
    repeat (3) tick();
    chk("hold_phase", 32'(phase), 3);
    tick();
  endtask

  initial begin
    rst = 1'b0;
    left_clicked = 1'b0;
    shot_done = 1'b0;
    shot_goal = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst_phase", 32'(phase), 0);
    chk("rst_round", 32'(round), 0);
    chk("rst_scores", 32'({score_player, score_opp}), 0);
    chk("rst_ps", 32'(player_shoots), 0);
    chk("rst_winner", 32'(winner), 0);

    // Reset in the middle of a shot
    click();
    chk("idle_to_aim", 32'(phase), 1);
    chk("aim_round", 32'(round), 1);
    chk("aim_ps", 32'(player_shoots), 1);
    click();
    chk("aim_to_shot", 32'(phase), 2);
    chk("fire_pulse", 32'(shot_fire), 1);
    tick();
    chk("fire_one_cycle", 32'(shot_fire), 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midshot_rst_phase", 32'(phase), 0);
    chk("midshot_rst_round", 32'(round), 0);
    chk("midshot_rst_ps", 32'(player_shoots), 0);

    // Game A: player wins early 2-0 after round 2
    click();
    chk("a_aim", 32'(phase), 1);
    take_shot(1'b1);
    chk("a_sp1", 32'(score_player), 1);
    hold_result();
    chk("a_r1_opp_phase", 32'(phase), 1);
    chk("a_r1_opp_ps", 32'(player_shoots), 0);
    chk("a_r1_opp_round", 32'(round), 1);
    repeat (19) tick();
    chk("a_before_timeout", 32'(phase), 1);
    tick();
    chk("a_timeout_phase", 32'(phase), 3);
    chk("a_timeout_flag", 32'(timed_out), 1);
    chk("a_timeout_lg", 32'(last_goal), 0);
    chk("a_timeout_scores", 32'({score_player, score_opp}), 32'h10);
    hold_result();
    chk("a_r2_phase", 32'(phase), 1);
    chk("a_r2_round", 32'(round), 2);
    chk("a_r2_ps", 32'(player_shoots), 1);
    chk("a_r2_to_clear", 32'(timed_out), 0);
    take_shot(1'b1);
    chk("a_sp2", 32'(score_player), 2);
    hold_result();
    chk("a_r2_opp_phase", 32'(phase), 1);
    chk("a_r2_opp_ps", 32'(player_shoots), 0);
    take_shot(1'b0);
    hold_result();
    chk("a_early_over", 32'(phase), 4);
    chk("a_winner", 32'(winner), 1);
    chk("a_over_round", 32'(round), 2);
    shot_done = 1'b1;
    shot_goal = 1'b1;
    tick();
    shot_done = 1'b0;
    shot_goal = 1'b0;
    tick();
    chk("a_over_frozen_phase", 32'(phase), 4);
    chk("a_over_frozen_scores", 32'({score_player, score_opp}), 32'h20);
    click();
    chk("a_back_idle", 32'(phase), 0);
    chk("a_idle_round", 32'(round), 0);

    // Game B: ignored inputs, shot_done vs expiry, 2-2 after regulation
    click();
    chk("b_aim", 32'(phase), 1);
    shot_done = 1'b1;
    shot_goal = 1'b1;
    tick();
    shot_done = 1'b0;
    shot_goal = 1'b0;
    chk("b_done_in_aim_phase", 32'(phase), 1);
    chk("b_done_in_aim_score", 32'(score_player), 0);
    click();
    chk("b_shot", 32'(phase), 2);
    click();
    chk("b_click_in_shot", 32'(phase), 2);
    repeat (14) tick();
    chk("b_shot_at_last_cycle", 32'(phase), 2);
    shot_done = 1'b1;
    shot_goal = 1'b1;
    tick();
    shot_done = 1'b0;
    shot_goal = 1'b0;
    chk("b_tie_phase", 32'(phase), 3);
    chk("b_tie_last_goal", 32'(last_goal), 1);
    chk("b_tie_timed_out", 32'(timed_out), 0);
    chk("b_tie_score", 32'(score_player), 1);
    hold_result();
    chk("b_r1_opp_ps", 32'(player_shoots), 0);
    take_shot(1'b1);
    chk("b_so1", 32'(score_opp), 1);
    hold_result();
    chk("b_r2_round", 32'(round), 2);
    take_shot(1'b0);
    hold_result();
    take_shot(1'b0);
    hold_result();
    chk("b_r3_round", 32'(round), 3);
    chk("b_r3_ps", 32'(player_shoots), 1);
    take_shot(1'b1);
    hold_result();
    chk("b_r3_opp_phase", 32'(phase), 1);
    take_shot(1'b1);
    chk("b_reg_scores", 32'({score_player, score_opp}), 32'h22);
    hold_result();
`ifdef SUDDEN_DEATH_EN
    chk("b_sd_phase", 32'(phase), 1);
    chk("b_sd_round", 32'(round), 4);
    chk("b_sd_ps", 32'(player_shoots), 1);
    take_shot(1'b1);
    hold_result();
    chk("b_sd_opp_phase", 32'(phase), 1);
    chk("b_sd_opp_ps", 32'(player_shoots), 0);
    take_shot(1'b0);
    hold_result();
    chk("b_sd_over", 32'(phase), 4);
    chk("b_sd_winner", 32'(winner), 1);
    chk("b_sd_scores", 32'({score_player, score_opp}), 32'h32);
`else
    chk("b_draw_over", 32'(phase), 4);
    chk("b_draw_winner", 32'(winner), 3);
    chk("b_draw_round", 32'(round), 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
